erase_character: RTL and testbench

- Pixel-writer counterpart to DrawCharacter. On a start request it overwrites the character sprite at the previous position (PrevState from CharacterFSM) with background colour.
- Emits one (XOut, YOut, Color, Plot) pixel write per cycle to the 160x120 VGA adapter port.
- Signals completion with a one-cycle done pulse, so the top level can sequence draw after erase.

---
 rtl/game_pkg.sv | 34 +++
 rtl/erase_character_if.sv | 30 +++
 rtl/sprite_scan_counter.sv | 53 +++++
 rtl/erase_character.sv | 140 ++++++++++++++
 tb/tb_erase_character.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game constants and FSM encoding.
// Holds the screen geometry, character placement and colours used by both
// DrawCharacter and erase_character, so both blocks address identical sprite
// rectangles. Also holds the IDLE/ERASE/DONE state encoding and a width helper.
package game_pkg;

    // Character placement on the 160x120 VGA canvas
    localparam int NUM_POS    = 4;
    localparam int LANE_WIDTH = 40;
    localparam int X_ORIGIN   = 12;
    localparam int Y_ORIGIN   = 96;
    localparam int SPRITE_W   = 16;
    localparam int SPRITE_H   = 16;

    // Screen limits of the VGA adapter
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Colours
    localparam logic [2:0] COLOR_BG   = 3'b000;
    localparam logic [2:0] COLOR_CHAR = 3'b111;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ERASE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Counter width for a range of n values, never less than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/erase_character_if.sv
// Pixel-writer bus between the game top level and erase_character.
// Handshake: Start is a request; it is accepted on a rising edge where Start=1
// and Busy=0. Busy rises the cycle after accept and stays high through the
// DoneErasing pulse, so a requester simply holds Start until it sees Busy.
// XOut/YOut/Color/Plot form one pixel write per cycle to the VGA adapter and
// are only meaningful while Plot=1. dbg_state exposes the FSM state.
interface erase_character_if;
    import game_pkg::*;

    logic       Start;
    logic [3:0] PrevState;
    logic [7:0] XOut;
    logic [6:0] YOut;
    logic [2:0] Color;
    logic       Plot;
    logic       Busy;
    logic       DoneErasing;
    state_t     dbg_state;

    modport master (
        output Start, PrevState,
        input  XOut, YOut, Color, Plot, Busy, DoneErasing, dbg_state
    );

    modport slave (
        input  Start, PrevState,
        output XOut, YOut, Color, Plot, Busy, DoneErasing, dbg_state
    );

endinterface

// File: rtl/sprite_scan_counter.sv
// Raster counter over a W x H sprite: px runs fastest, py steps when px wraps.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - force (0,0) on the next edge
//   en        - advance to the next pixel
//   px, py    - pixel currently addressed
//   px_nxt,   - the pixel that follows (px,py) in raster order, so a caller
//   py_nxt      can register coordinates one pixel ahead
//   last      - (px,py) is the bottom-right pixel
module sprite_scan_counter
    import game_pkg::*;
#(
    parameter int W = SPRITE_W,
    parameter int H = SPRITE_H,
    localparam int PX_W = clog2_min1(W),
    localparam int PY_W = clog2_min1(H)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            en,
    output logic [PX_W-1:0] px,
    output logic [PY_W-1:0] py,
    output logic [PX_W-1:0] px_nxt,
    output logic [PY_W-1:0] py_nxt,
    output logic            last
);

    logic row_end;
    logic col_end;

    always_comb begin
        row_end = (px == PX_W'(W - 1));
        col_end = (py == PY_W'(H - 1));
        last    = row_end && col_end;
        px_nxt  = row_end ? '0 : px + PX_W'(1);
        py_nxt  = py;
        if (row_end) begin
            py_nxt = col_end ? '0 : py + PY_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            px <= '0;
            py <= '0;
        end else if (en) begin
            px <= px_nxt;
            py <= py_nxt;
        end
    end

endmodule

// File: rtl/erase_character.sv
// Overwrites the character sprite at a previous position with background colour.
// On an accepted Start it emits one registered pixel write per cycle in raster
// order, then pulses DoneErasing for one cycle so the top level can sequence
// the draw that follows.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   Reset    - synchronous active-high reset
//   bus      - erase_character_if.slave: Start/PrevState request in,
//              XOut/YOut/Color/Plot pixel writes, Busy, DoneErasing, dbg_state out
module erase_character
    import game_pkg::*;
#(
    parameter int         NUM_POS    = game_pkg::NUM_POS,
    parameter int         LANE_WIDTH = game_pkg::LANE_WIDTH,
    parameter int         X_ORIGIN   = game_pkg::X_ORIGIN,
    parameter int         Y_ORIGIN   = game_pkg::Y_ORIGIN,
    parameter int         SPRITE_W   = game_pkg::SPRITE_W,
    parameter int         SPRITE_H   = game_pkg::SPRITE_H,
    parameter logic [2:0] BG_COLOR   = COLOR_BG
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    erase_character_if.slave  bus
);

    localparam int PX_W = clog2_min1(SPRITE_W);
    localparam int PY_W = clog2_min1(SPRITE_H);

    state_t          state;
    logic [3:0]      pos;
    logic [7:0]      x_q;
    logic [6:0]      y_q;
    logic            plot_q;

    logic [PX_W-1:0] px, px_nxt, src_px;
    logic [PY_W-1:0] py, py_nxt, src_py;
    logic [3:0]      src_pos;
    logic            cnt_last;
    logic            cnt_clear;
    logic            cnt_en;
    logic            pos_valid;
    logic [8:0]      nx_x;
    logic [7:0]      nx_y;
    logic            nx_inb;

    sprite_scan_counter #(
        .W (SPRITE_W),
        .H (SPRITE_H)
    ) u_scan (
        .clk    (CLOCK_50),
        .rst    (Reset),
        .clear  (cnt_clear),
        .en     (cnt_en),
        .px     (px),
        .py     (py),
        .px_nxt (px_nxt),
        .py_nxt (py_nxt),
        .last   (cnt_last)
    );

    // Output registers are loaded one pixel ahead of the counter: on accept
    // they take pixel (0,0) of the requested position, afterwards the pixel
    // following the one the counter currently holds. This puts the first
    // write in the cycle right after accept with no bubble.
    always_comb begin
        pos_valid = (int'(bus.PrevState) < NUM_POS);
        cnt_clear = (state == ST_IDLE) && bus.Start && pos_valid;
        cnt_en    = (state == ST_ERASE) && !cnt_last;

        if (state == ST_IDLE) begin
            src_pos = bus.PrevState;
            src_px  = '0;
            src_py  = '0;
        end else begin
            src_pos = pos;
            src_px  = px_nxt;
            src_py  = py_nxt;
        end

        // Off-screen pixels are still scanned (latency is fixed) but not plotted
        nx_x   = 9'(X_ORIGIN + int'(src_pos) * LANE_WIDTH + int'(src_px));
        nx_y   = 8'(Y_ORIGIN + int'(src_py));
        nx_inb = (nx_x < 9'(SCREEN_W)) && (nx_y < 8'(SCREEN_H));
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state  <= ST_IDLE;
            pos    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            plot_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    plot_q <= 1'b0;
                    if (bus.Start) begin
                        if (pos_valid) begin
                            pos    <= bus.PrevState;
                            x_q    <= nx_x[7:0];
                            y_q    <= nx_y[6:0];
                            plot_q <= nx_inb;
                            state  <= ST_ERASE;
                        end else begin
                            // Nothing to erase; still report completion
                            state <= ST_DONE;
                        end
                    end
                end
                ST_ERASE: begin
                    if (cnt_last) begin
                        plot_q <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        x_q    <= nx_x[7:0];
                        y_q    <= nx_y[6:0];
                        plot_q <= nx_inb;
                    end
                end
                ST_DONE: begin
                    plot_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    plot_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.XOut        = x_q;
    assign bus.YOut        = y_q;
    assign bus.Color       = BG_COLOR;
    assign bus.Plot        = plot_q;
    assign bus.Busy        = (state != ST_IDLE);
    assign bus.DoneErasing = (state == ST_DONE);
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_erase_character.sv
// Bench for erase_character: a default instance and one with X_ORIGIN=150 to
// exercise off-screen suppression. Expected pixel writes (tagged with the
// cycle they must appear in) and done cycles are queued when Start is driven,
// and popped by per-instance monitors on the falling edge.
module tb_erase_character;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   errors;

    logic [46:0] exp_q0[$];
    logic [46:0] exp_q1[$];
    int          done_q0[$];
    int          done_q1[$];

    erase_character_if bus0();
    erase_character_if bus1();

    erase_character u_dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .bus      (bus0)
    );

    erase_character #(
        .X_ORIGIN (150)
    ) u_dut_edge (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .bus      (bus1)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cyc equals the current cycle number when sampled on the falling edge
    initial cyc = 1;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue the writes of an erase accepted at the edge ending cycle t.
    // limit caps the number of scanned pixel slots (to model an abort by reset).
    task automatic push_erase(input int which, input int p, input int t,
                              input int xo, input int limit);
        int x;
        int y;
        int k;
        logic [46:0] e;
        if (p >= 4) begin
            if (which == 0) done_q0.push_back(t + 1);
            else            done_q1.push_back(t + 1);
            return;
        end
        for (int py = 0; py < 16; py++) begin
            for (int px = 0; px < 16; px++) begin
                k = py * 16 + px;
                x = xo + p * 40 + px;
                y = 96 + py;
                if (k < limit && x < 160 && y < 120) begin
                    e = {32'(t + 1 + k), 8'(x), 7'(y)};
                    if (which == 0) exp_q0.push_back(e);
                    else            exp_q1.push_back(e);
                end
            end
        end
        if (limit >= 256) begin
            if (which == 0) done_q0.push_back(t + 257);
            else            done_q1.push_back(t + 257);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        check("color0", 64'(bus0.Color), 64'd0);
        if (bus0.Plot) begin
            if (exp_q0.size() == 0) check("extra_plot0", 64'(cyc), 64'd0);
            else check("pix0", 64'({32'(cyc), bus0.XOut, bus0.YOut}), 64'(exp_q0.pop_front()));
        end
        if (bus0.DoneErasing) begin
            if (done_q0.size() == 0) check("extra_done0", 64'(cyc), 64'd0);
            else check("done0", 64'(cyc), 64'(done_q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        check("color1", 64'(bus1.Color), 64'd0);
        if (bus1.Plot) begin
            if (exp_q1.size() == 0) check("extra_plot1", 64'(cyc), 64'd0);
            else check("pix1", 64'({32'(cyc), bus1.XOut, bus1.YOut}), 64'(exp_q1.pop_front()));
        end
        if (bus1.DoneErasing) begin
            if (done_q1.size() == 0) check("extra_done1", 64'(cyc), 64'd0);
            else check("done1", 64'(cyc), 64'(done_q1.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a falling edge: raise Start for one cycle and queue the model.
    task automatic start_pulse(input int which, input int p, output int t);
        t = cyc;
        if (which == 0) begin
            bus0.Start = 1'b1;
            bus0.PrevState = 4'(p);
            push_erase(0, p, t, 12, 256);
        end else begin
            bus1.Start = 1'b1;
            bus1.PrevState = 4'(p);
            push_erase(1, p, t, 150, 256);
        end
        @(negedge clk);
        bus0.Start = 1'b0;
        bus1.Start = 1'b0;
        // Changing the index after accept must not matter
        bus0.PrevState = 4'(p + 1);
        bus1.PrevState = 4'(p + 1);
    endtask

    // Wait (bounded) for every queued expectation to be consumed.
    task automatic drain(input string tag);
        for (int i = 0; i < 1200; i++) begin
            if (exp_q0.size() == 0 && exp_q1.size() == 0 &&
                done_q0.size() == 0 && done_q1.size() == 0) break;
            @(negedge clk);
        end
        check({tag, "_left_pix0"}, 64'(exp_q0.size()), 64'd0);
        check({tag, "_left_pix1"}, 64'(exp_q1.size()), 64'd0);
        check({tag, "_left_done"}, 64'(done_q0.size() + done_q1.size()), 64'd0);
        exp_q0.delete();
        exp_q1.delete();
        done_q0.delete();
        done_q1.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_plot"}, 64'(bus0.Plot), 64'd0);
        check({tag, "_busy"}, 64'(bus0.Busy), 64'd0);
        check({tag, "_done"}, 64'(bus0.DoneErasing), 64'd0);
        check({tag, "_state"}, 64'(bus0.dbg_state), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int p;
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        bus0.Start = 1'b0;
        bus0.PrevState = 4'd0;
        bus1.Start = 1'b0;
        bus1.PrevState = 4'd0;

        // Reset held three cycles
        repeat (3) begin
            @(negedge clk);
            check_idle("reset");
            check("reset_x", 64'(bus0.XOut), 64'd0);
            check("reset_y", 64'(bus0.YOut), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");
        repeat (2) @(negedge clk);

        // Single pulse, position 2
        start_pulse(0, 2, t);
        check("p2_first_plot", 64'(bus0.Plot), 64'd1);
        check("p2_first_xy", 64'({bus0.XOut, bus0.YOut}), 64'({8'd92, 7'd96}));
        check("p2_busy", 64'(bus0.Busy), 64'd1);
        drain("p2");
        check_idle("p2_after");

        // Start held for 300 cycles at position 3: accepts at t and t+258
        t = cyc;
        bus0.Start = 1'b1;
        bus0.PrevState = 4'd3;
        push_erase(0, 3, t, 12, 256);
        push_erase(0, 3, t + 258, 12, 256);
        repeat (300) @(negedge clk);
        bus0.Start = 1'b0;
        check("held_busy_at_end", 64'(bus0.Busy), 64'd1);
        drain("held");

        // Invalid index: straight to done, no writes
        check("inv_busy_before", 64'(bus0.Busy), 64'd0);
        start_pulse(0, 7, t);
        check("inv_busy", 64'(bus0.Busy), 64'd1);
        check("inv_plot", 64'(bus0.Plot), 64'd0);
        @(negedge clk);
        check("inv_busy_after", 64'(bus0.Busy), 64'd0);
        drain("inv");

        // Reset at the 100th write of a position-0 erase
        t = cyc;
        bus0.Start = 1'b1;
        bus0.PrevState = 4'd0;
        push_erase(0, 0, t, 12, 100);
        @(negedge clk);
        bus0.Start = 1'b0;
        repeat (99) @(negedge clk);
        check("rst_mid_plot_before", 64'(bus0.Plot), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        drain("rst_mid");
        start_pulse(0, 0, t);
        check("fresh_xy", 64'({bus0.XOut, bus0.YOut}), 64'({8'd12, 7'd96}));
        check("fresh_plot", 64'(bus0.Plot), 64'd1);
        drain("fresh");

        // Right-edge clipping on the X_ORIGIN=150 instance
        start_pulse(1, 0, t);
        check("edge_first_xy", 64'({bus1.XOut, bus1.YOut}), 64'({8'd150, 7'd96}));
        drain("edge");

        // A few random indices, valid and invalid
        for (int i = 0; i < 4; i++) begin
            p = $urandom_range(0, 7);
            start_pulse(0, p, t);
            drain("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
